// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/func constants and the fetch-unit state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ready port and
// presents each word with its split fields over a valid/ack handshake.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ack,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [1:0]        dbg_state
);

  // Handshakes: a fetch completes on any cycle with imem_req && imem_ready;
  // an instruction is consumed on any cycle with instr_valid && instr_ack.
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drain_addr;
  logic [ADDR_W-1:0] r_pc_out;
  logic [31:0]       r_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] w_target;

  assign w_target = branch_target & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH: begin
        if (imem_ready)        w_next_state = branch_taken ? FETCH : ISSUE;
        else if (branch_taken) w_next_state = DRAIN;
      end
      DRAIN: if (imem_ready) w_next_state = FETCH;
      ISSUE: if (instr_ack || branch_taken) w_next_state = FETCH;
      default: w_next_state = FETCH;
    endcase
  end

  // The request is suppressed during the reset cycle itself so a dropped
  // transfer never looks like a fresh one.
  always_comb begin
    imem_req  = !reset && (r_state != ISSUE);
    imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;
    dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_pc_out     <= '0;
      r_instr      <= '0;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ready && !branch_taken) begin
            r_instr  <= imem_rdata;
            r_pc_out <= r_pc;
            r_pc     <= r_pc + PC_STEP;
            r_valid  <= 1'b1;
          end else if (branch_taken) begin
            // Remember the abandoned address so it stays on the bus until ready.
            if (!imem_ready) r_drain_addr <= r_pc;
            r_pc <= w_target;
          end
        end
        DRAIN: if (branch_taken) r_pc <= w_target;
        ISSUE: begin
          if (instr_ack || branch_taken) r_valid <= 1'b0;
          if (branch_taken)              r_pc    <= w_target;
        end
        default: ;
      endcase
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc_out      = r_pc_out;
  assign pc_plus4    = r_pc_out + PC_STEP;
  assign opcode      = r_instr[31:26];
  assign func        = r_instr[5:0];
  assign rs          = r_instr[25:21];
  assign rt          = r_instr[20:16];
  assign rd          = r_instr[15:11];
  assign imm         = r_instr[15:0];

endmodule
